// File: rtl/div_unit.sv
// div_unit: multi-cycle radix-2 restoring divider for RV64M div/divu/rem/remu
// and their *w variants. Valid/ready on both sides; flush kills any operation.
// Optional build macro: DIV_EARLY_OUT_EN (skip iteration when |dividend| < |divisor|).
module div_unit #(
    parameter int unsigned XLEN = 64
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] dividend,
    input  logic [XLEN-1:0] divisor,
    input  logic            is_signed,
    input  logic            is_word,
    input  logic            want_rem,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result
);

    localparam int unsigned WLEN = 32;
    localparam int unsigned CW   = $clog2(XLEN + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state, state_nx;

    logic [CW-1:0]   cnt;
    logic [XLEN-1:0] quo, rem, dvs;
    logic            neg_q, neg_r, word_op, rem_op;

    logic [XLEN-1:0] a_ext_c, b_ext_c, a_mag_c, b_mag_c;
    logic            a_neg_c, b_neg_c, div_zero_c, early_c, skip_c, accept_c;
    logic [XLEN-1:0] direct_res_c;

    logic [XLEN:0]   shifted_c, trial_c;
    logic [XLEN-1:0] quo_nx_c, rem_nx_c, q_fin_c, r_fin_c, calc_res_c;

    // Sign-extend the low word for *w results, pass through otherwise
    function automatic logic [XLEN-1:0] word_fix(input logic [XLEN-1:0] x, input logic w);
        return w ? {{(XLEN-WLEN){x[WLEN-1]}}, x[WLEN-1:0]} : x;
    endfunction

    // Operand preparation: width/sign extension and magnitudes of the incoming packet
    always_comb begin
        a_ext_c = dividend;
        b_ext_c = divisor;
        if (is_word) begin
            if (is_signed) begin
                a_ext_c = {{(XLEN-WLEN){dividend[WLEN-1]}}, dividend[WLEN-1:0]};
                b_ext_c = {{(XLEN-WLEN){divisor[WLEN-1]}},  divisor[WLEN-1:0]};
            end else begin
                a_ext_c = {{(XLEN-WLEN){1'b0}}, dividend[WLEN-1:0]};
                b_ext_c = {{(XLEN-WLEN){1'b0}}, divisor[WLEN-1:0]};
            end
        end
        a_neg_c    = is_signed & a_ext_c[XLEN-1];
        b_neg_c    = is_signed & b_ext_c[XLEN-1];
        a_mag_c    = a_neg_c ? (~a_ext_c + XLEN'(1)) : a_ext_c;
        b_mag_c    = b_neg_c ? (~b_ext_c + XLEN'(1)) : b_ext_c;
        div_zero_c = (b_ext_c == '0);
    end

`ifdef DIV_EARLY_OUT_EN
    assign early_c = ~div_zero_c & (a_mag_c < b_mag_c);
`else
    assign early_c = 1'b0;
`endif

    assign skip_c = div_zero_c | early_c;

    // Result for operations that bypass iteration (divide by zero, early out)
    always_comb begin
        direct_res_c = '0;
        if (want_rem) begin
            direct_res_c = word_fix(a_ext_c, is_word);
        end else if (div_zero_c) begin
            direct_res_c = {XLEN{1'b1}};
        end
    end

    // One restoring step plus the sign fix applied when the last step completes
    always_comb begin
        shifted_c = {rem, quo[XLEN-1]};
        trial_c   = shifted_c - {1'b0, dvs};
        quo_nx_c  = {quo[XLEN-2:0], ~trial_c[XLEN]};
        rem_nx_c  = trial_c[XLEN] ? shifted_c[XLEN-1:0] : trial_c[XLEN-1:0];
        q_fin_c   = neg_q ? (~quo_nx_c + XLEN'(1)) : quo_nx_c;
        r_fin_c   = neg_r ? (~rem_nx_c + XLEN'(1)) : rem_nx_c;
        calc_res_c = word_fix(rem_op ? r_fin_c : q_fin_c, word_op);
    end

    // Next-state logic; flush overrides everything including a same-cycle accept
    always_comb begin
        state_nx = state;
        accept_c = 1'b0;
        case (state)
            IDLE: begin
                if (in_valid && in_ready) begin
                    accept_c = 1'b1;
                    state_nx = skip_c ? DONE : CALC;
                end
            end
            CALC: begin
                if (cnt == CW'(1)) begin
                    state_nx = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
        if (flush) begin
            state_nx = IDLE;
            accept_c = 1'b0;
        end
    end

    // State register and registered handshake outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            state     <= state_nx;
            in_ready  <= (state_nx == IDLE);
            out_valid <= (state_nx == DONE);
        end
    end

    // Datapath: capture at accept, iterate in CALC, load result on entry to DONE
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt     <= '0;
            quo     <= '0;
            rem     <= '0;
            dvs     <= '0;
            neg_q   <= 1'b0;
            neg_r   <= 1'b0;
            word_op <= 1'b0;
            rem_op  <= 1'b0;
            result  <= '0;
        end else if (flush) begin
            cnt <= '0;
        end else if (accept_c) begin
            // Word dividends are pre-shifted so the top of quo feeds the first step
            quo     <= is_word ? XLEN'(a_mag_c << WLEN) : a_mag_c;
            rem     <= '0;
            dvs     <= b_mag_c;
            neg_q   <= a_neg_c ^ b_neg_c;
            neg_r   <= a_neg_c;
            word_op <= is_word;
            rem_op  <= want_rem;
            if (skip_c) begin
                cnt    <= '0;
                result <= direct_res_c;
            end else begin
                cnt <= is_word ? CW'(WLEN) : CW'(XLEN);
            end
        end else if (state == CALC) begin
            quo <= quo_nx_c;
            rem <= rem_nx_c;
            cnt <= cnt - CW'(1);
            if (cnt == CW'(1)) begin
                result <= calc_res_c;
            end
        end
    end

endmodule
